// File: rtl/cdr_pkg.sv
// Shared types and helpers for the CDR loop filter: FSM state encoding and
// the saturating adder used by both the integrator and the control-word clamp.
package cdr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    TRACK
  } cdr_lf_state_t;

  typedef struct packed {
    logic signed [31:0] value;
    logic               clamped;
  } sat_res_t;

  // Sum is formed one bit wider than the operands so the bound checks never see a wrapped result.
  function automatic sat_res_t sat_add(input logic signed [31:0] a,
                                       input logic signed [31:0] b,
                                       input logic signed [31:0] lo,
                                       input logic signed [31:0] hi);
    logic signed [32:0] s;
    sat_res_t r;
    s = 33'(a) + 33'(b);
    r.clamped = 1'b1;
    if (s < lo) begin
      r.value = lo;
    end else if (s > hi) begin
      r.value = hi;
    end else begin
      r.value   = s[31:0];
      r.clamped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cdr_loop_filter.sv
// Proportional-integral loop filter turning PFD up/down pulses into a saturated
// oscillator control word, updated once per DECIM-cycle window, with lock detect.
module cdr_loop_filter
  import cdr_pkg::*;
#(
  parameter int CW       = 10,
  parameter int IW       = 16,
  parameter int DECIM    = 8,
  parameter int KP_SHIFT = 2,
  parameter int KI_SHIFT = 6,
  parameter int LOCK_CNT = 16
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          en,
  input  logic          up,
  input  logic          down,
  output logic [CW-1:0] ctrl,
  output logic          ctrl_valid,
  output logic          locked,
  output logic          sat
);

  localparam int WCW      = $clog2(DECIM);
  localparam int WW       = WCW + 2;
  localparam int QW       = $clog2(LOCK_CNT + 1);
  localparam int CTRL_MID = 2 ** (CW - 1);
  localparam logic signed [31:0] IMAX = 32'sd2 ** (IW - 1) - 32'sd1;
  localparam logic signed [31:0] IMIN = -(32'sd2 ** (IW - 1));
  localparam logic signed [31:0] CMAX = 32'sd2 ** CW - 32'sd1;

  logic up_s, down_s;

  sync_2ff u_sync_up   (.clk(refclk), .rst(rst), .d(up),   .q(up_s));
  sync_2ff u_sync_down (.clk(refclk), .rst(rst), .d(down), .q(down_s));

  cdr_lf_state_t        state;
  logic [WCW-1:0]       win_cnt;
  logic signed [WW-1:0] werr;
  logic signed [IW-1:0] integ;
  logic [QW-1:0]        quiet_cnt;

  logic signed [WW-1:0] e;
  logic signed [WW-1:0] werr_full;
  logic signed [31:0]   werr_ext;
  logic signed [31:0]   integ_new;
  logic signed [31:0]   ctrl_base;
  logic signed [31:0]   ctrl_new;
  sat_res_t             res_i;
  sat_res_t             res_c;
  logic                 close;
  logic                 quiet;
  logic                 wild;
  logic [QW-1:0]        qc_inc;

  // Window-close datapath: werr_full already includes this cycle's error.
  always_comb begin
    e = '0;
    if (up_s && !down_s) begin
      e = WW'(1);
    end else if (down_s && !up_s) begin
      e = '1;
    end
    werr_full = werr + e;
    werr_ext  = 32'(werr_full);
    res_i     = sat_add(32'(integ), werr_ext, IMIN, IMAX);
    integ_new = res_i.value;
    ctrl_base = CTRL_MID + (integ_new >>> KI_SHIFT);
    res_c     = sat_add(ctrl_base, werr_ext <<< KP_SHIFT, 32'sd0, CMAX);
    ctrl_new  = res_c.value;
    close     = (state != IDLE) && (win_cnt == WCW'(DECIM - 1));
    quiet     = (werr_ext >= -32'sd1) && (werr_ext <= 32'sd1);
    wild      = (werr_ext > DECIM / 2) || (werr_ext < -(DECIM / 2));
    qc_inc    = quiet_cnt + QW'(1);
  end

  logic unused_bits;
  assign unused_bits = ^{integ_new[31:IW], ctrl_new[31:CW], res_i.clamped};

  // A close always commits its update, even when en drops on that same cycle.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= IDLE;
      win_cnt    <= '0;
      werr       <= '0;
      integ      <= '0;
      quiet_cnt  <= '0;
      ctrl       <= CW'(CTRL_MID);
      ctrl_valid <= 1'b0;
      locked     <= 1'b0;
      sat        <= 1'b0;
    end else begin
      ctrl_valid <= 1'b0;
      if (close) begin
        integ      <= integ_new[IW-1:0];
        ctrl       <= ctrl_new[CW-1:0];
        sat        <= res_c.clamped;
        ctrl_valid <= 1'b1;
      end
      if (!en) begin
        state     <= IDLE;
        locked    <= 1'b0;
        win_cnt   <= '0;
        werr      <= '0;
        quiet_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state   <= ACQ;
            win_cnt <= '0;
            werr    <= '0;
          end
          ACQ, TRACK: begin
            if (close) begin
              win_cnt <= '0;
              werr    <= '0;
            end else begin
              win_cnt <= win_cnt + WCW'(1);
              werr    <= werr_full;
            end
            if (close && state == ACQ) begin
              if (quiet) begin
                quiet_cnt <= qc_inc;
                if (qc_inc == QW'(LOCK_CNT)) begin
                  state  <= TRACK;
                  locked <= 1'b1;
                end
              end else begin
                quiet_cnt <= '0;
              end
            end
            if (close && state == TRACK && wild) begin
              state     <= ACQ;
              locked    <= 1'b0;
              quiet_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
